// File: rtl/regfile_multiport_pkg.sv
// Shared register-file configuration for the CPU top and benches.
// Widths and defaults only; the REGFILE_ZERO_REG_EN option lives in the RTL.
package cpuConfig;

  localparam int REG_N      = 8;
  localparam int REG_R_SIZE = 2;
  localparam int REG_DEPTH  = 4;
  localparam int REG_NUM_RD = 2;

  typedef logic [REG_N-1:0]      reg_t;
  typedef logic [REG_R_SIZE-1:0] regAddr_t;

endpackage

// File: rtl/regfile_multiport_read_port.sv
// One combinational read port: out-of-range zero, write-back forward, else array.
// Optional macro REGFILE_ZERO_REG_EN hardwires address 0 to read as zero.
module regfile_read_port
  import cpuConfig::*;
#(
  parameter int N      = REG_N,
  parameter int R_SIZE = REG_R_SIZE,
  parameter int DEPTH  = REG_DEPTH
) (
  input  logic [R_SIZE-1:0]         addr,
  input  logic                      wbValid,
  input  logic [R_SIZE-1:0]         wbAddr,
  input  logic [N-1:0]              wbData,
  input  logic [DEPTH-1:0][N-1:0]   regs,
  output logic [N-1:0]              data
);

  logic          in_range;
  logic [N-1:0]  arr_data;

  always_comb begin
    in_range = 1'b0;
    arr_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == R_SIZE'(i)) begin
        in_range = 1'b1;
        arr_data = regs[i];
      end
    end
  end

  always_comb begin
    data = '0;
    if (in_range) begin
      // The pending write is newer than the array, so it takes precedence.
      if (wbValid && (wbAddr == addr)) data = wbData;
      else                             data = arr_data;
    end
`ifdef REGFILE_ZERO_REG_EN
    if (addr == '0) data = '0;
`endif
  end

endmodule

// File: rtl/regfile_multiport.sv
// DEPTH x N register file, NUM_RD forwarded read ports, one write port via a write-back stage.
// Optional macro REGFILE_ZERO_REG_EN makes register 0 read-only zero.
module regfile_multiport
  import cpuConfig::*;
#(
  parameter int N      = REG_N,
  parameter int R_SIZE = REG_R_SIZE,
  parameter int DEPTH  = REG_DEPTH,
  parameter int NUM_RD = REG_NUM_RD
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic [N-1:0]             dataIn,
  input  logic [R_SIZE-1:0]        dAddressIn,
  input  logic                     writeEnIn,
  input  logic [NUM_RD*R_SIZE-1:0] rdAddressIn,
  output logic [NUM_RD*N-1:0]      rdDataOut,
  output logic                     wbPendingOut
);

  logic [DEPTH-1:0][N-1:0] regs_q, regs_d;
  logic                    wb_valid_q, wb_valid_d;
  logic [R_SIZE-1:0]       wb_addr_q, wb_addr_d;
  logic [N-1:0]            wb_data_q, wb_data_d;
  logic                    wr_addr_ok;

  always_comb begin
    wr_addr_ok = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (dAddressIn == R_SIZE'(i)) wr_addr_ok = 1'b1;
    end
`ifdef REGFILE_ZERO_REG_EN
    if (dAddressIn == '0) wr_addr_ok = 1'b0;
`endif
  end

  // Capture of the new write and commit of the held one share an edge, so no stall.
  always_comb begin
    regs_d     = regs_q;
    wb_valid_d = writeEnIn && wr_addr_ok;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (wb_valid_q) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_addr_q == R_SIZE'(i)) regs_d[i] = wb_data_q;
      end
    end
    if (wb_valid_d) begin
      wb_addr_d = dAddressIn;
      wb_data_d = dataIn;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      regs_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wbPendingOut = wb_valid_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_read_port #(
      .N      (N),
      .R_SIZE (R_SIZE),
      .DEPTH  (DEPTH)
    ) u_rd (
      .addr    (rdAddressIn[p*R_SIZE +: R_SIZE]),
      .wbValid (wb_valid_q),
      .wbAddr  (wb_addr_q),
      .wbData  (wb_data_q),
      .regs    (regs_q),
      .data    (rdDataOut[p*N +: N])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport against an architectural register model.
// Honours REGFILE_ZERO_REG_EN when it is defined for the build.
module tb_regfile_multiport;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        nReset;
  logic [7:0]  dataIn;
  logic [1:0]  dAddressIn;
  logic        writeEnIn;
  logic [3:0]  rdAddressIn;
  logic [15:0] rdDataOut, rdDataOut3;
  logic        wbPendingOut, wbPendingOut3;

  int errors = 0;
  int checks = 0;

  // Architectural view: a write is visible from the edge that accepts it.
  logic [7:0] vis [4];
  logic       pend;

  always #5 clk = ~clk;

  regfile_multiport #(.N(8), .R_SIZE(2), .DEPTH(4), .NUM_RD(2)) dut (
    .clk(clk), .nReset(nReset), .dataIn(dataIn), .dAddressIn(dAddressIn),
    .writeEnIn(writeEnIn), .rdAddressIn(rdAddressIn), .rdDataOut(rdDataOut),
    .wbPendingOut(wbPendingOut)
  );

  regfile_multiport #(.N(8), .R_SIZE(2), .DEPTH(3), .NUM_RD(2)) dut3 (
    .clk(clk), .nReset(nReset), .dataIn(dataIn), .dAddressIn(dAddressIn),
    .writeEnIn(writeEnIn), .rdAddressIn(rdAddressIn), .rdDataOut(rdDataOut3),
    .wbPendingOut(wbPendingOut3)
  );

  function automatic bit zero_reg_en();
`ifdef REGFILE_ZERO_REG_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_rd(input logic [1:0] a);
    if (int'(a) >= D) return 8'h00;
    if (zero_reg_en() && a == 2'd0) return 8'h00;
    return vis[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) vis[i] = 8'h00;
    pend = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (writeEnIn && int'(dAddressIn) < D && !(zero_reg_en() && dAddressIn == 2'd0)) begin
      vis[dAddressIn] = dataIn;
      pend = 1'b1;
    end else begin
      pend = 1'b0;
    end
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] a, input logic [7:0] d,
                       input logic [1:0] r0, input logic [1:0] r1);
    writeEnIn   = we;
    dAddressIn  = a;
    dataIn      = d;
    rdAddressIn = {r1, r0};
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 2'd1, 2'd2);
    model_clear();
    #12;
    checks++;
    if (wbPendingOut !== 1'b0) begin
      errors++; $display("FAIL reset_pending: got %b want 0", wbPendingOut);
    end
    checks++;
    if (rdDataOut !== 16'h0000) begin
      errors++; $display("FAIL reset_rd: got %h want 0000", rdDataOut);
    end
    nReset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_forward();
    drive(1'b1, 2'd2, 8'hE9, 2'd2, 2'd0);
    tick();
    checks++;
    if (rdDataOut[7:0] !== 8'hE9 || wbPendingOut !== 1'b1) begin
      errors++; $display("FAIL fwd_r2: got %h pend %b want e9 pend 1", rdDataOut[7:0], wbPendingOut);
    end
    drive(1'b0, 2'd0, 8'h00, 2'd2, 2'd2);
    tick();
    checks++;
    if (rdDataOut !== 16'hE9E9 || wbPendingOut !== 1'b0) begin
      errors++; $display("FAIL commit_r2: got %h pend %b want e9e9 pend 0", rdDataOut, wbPendingOut);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'd1, 8'h11, 2'd1, 2'd1);
    tick();
    checks++;
    if (rdDataOut !== 16'h1111) begin
      errors++; $display("FAIL b2b_first: got %h want 1111", rdDataOut);
    end
    drive(1'b1, 2'd1, 8'h22, 2'd1, 2'd1);
    tick();
    checks++;
    if (rdDataOut !== 16'h2222 || wbPendingOut !== 1'b1) begin
      errors++; $display("FAIL b2b_second: got %h pend %b want 2222 pend 1", rdDataOut, wbPendingOut);
    end
    drive(1'b0, 2'd0, 8'h00, 2'd1, 2'd1);
    tick();
    checks++;
    if (rdDataOut !== 16'h2222) begin
      errors++; $display("FAIL b2b_settle: got %h want 2222", rdDataOut);
    end
  endtask

  task automatic test_same_cycle();
    drive(1'b1, 2'd3, 8'h5A, 2'd0, 2'd3);
    #1;
    checks++;
    if (rdDataOut[15:8] !== exp_rd(2'd3)) begin
      errors++; $display("FAIL same_cycle_old: got %h want %h", rdDataOut[15:8], exp_rd(2'd3));
    end
    tick();
    checks++;
    if (rdDataOut[15:8] !== 8'h5A) begin
      errors++; $display("FAIL same_cycle_new: got %h want 5a", rdDataOut[15:8]);
    end
    drive(1'b0, 2'd0, 8'h00, 2'd3, 2'd3);
    tick();
  endtask

  task automatic test_depth3();
    drive(1'b1, 2'd3, 8'hFF, 2'd3, 2'd3);
    tick();
    checks++;
    if (wbPendingOut3 !== 1'b0) begin
      errors++; $display("FAIL depth3_pending: got %b want 0", wbPendingOut3);
    end
    checks++;
    if (rdDataOut3 !== 16'h0000) begin
      errors++; $display("FAIL depth3_rd: got %h want 0000", rdDataOut3);
    end
    checks++;
    if (rdDataOut !== 16'hFFFF) begin
      errors++; $display("FAIL depth4_r3: got %h want ffff", rdDataOut);
    end
    drive(1'b0, 2'd0, 8'h00, 2'd3, 2'd3);
    tick();
  endtask

  task automatic test_zero_reg();
    logic [7:0] want;
    want = zero_reg_en() ? 8'h00 : 8'h7E;
    drive(1'b1, 2'd0, 8'h7E, 2'd0, 2'd0);
    tick();
    checks++;
    if (rdDataOut !== {want, want} || wbPendingOut !== pend) begin
      errors++; $display("FAIL zero_reg_fwd: got %h pend %b want %h pend %b", rdDataOut, wbPendingOut, {want, want}, pend);
    end
    drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
    tick();
    checks++;
    if (rdDataOut !== {want, want}) begin
      errors++; $display("FAIL zero_reg_commit: got %h want %h", rdDataOut, {want, want});
    end
  endtask

  task automatic test_random();
    logic [1:0] r0, r1;
    for (int i = 0; i < 300; i++) begin
      r0 = 2'($urandom_range(0, 3));
      r1 = 2'($urandom_range(0, 3));
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), r0, r1);
      #1;
      checks++;
      if (rdDataOut !== {exp_rd(r1), exp_rd(r0)}) begin
        errors++; $display("FAIL rand_pre_edge[%0d]: got %h want %h", i, rdDataOut, {exp_rd(r1), exp_rd(r0)});
      end
      tick();
      checks++;
      if (rdDataOut !== {exp_rd(r1), exp_rd(r0)} || wbPendingOut !== pend) begin
        errors++; $display("FAIL rand_post_edge[%0d]: got %h pend %b want %h pend %b", i, rdDataOut, wbPendingOut, {exp_rd(r1), exp_rd(r0)}, pend);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'd1, 8'hA5, 2'd1, 2'd2);
    tick();
    drive(1'b0, 2'd0, 8'h00, 2'd1, 2'd2);
    #2;
    nReset = 1'b0;
    #1;
    checks++;
    if (rdDataOut !== 16'h0000 || wbPendingOut !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got %h pend %b want 0000 pend 0", rdDataOut, wbPendingOut);
    end
    #1;
    nReset = 1'b1;
    model_clear();
    tick();
    checks++;
    if (rdDataOut !== 16'h0000 || wbPendingOut !== 1'b0) begin
      errors++; $display("FAIL after_reset: got %h pend %b want 0000 pend 0", rdDataOut, wbPendingOut);
    end
  endtask

  initial begin
    test_reset();
    test_write_forward();
    test_back_to_back();
    test_same_cycle();
    test_depth3();
    test_zero_reg();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
